seq_div: RTL and testbench
==========================

// Module: seq_div
// PURPOSE
//   Multi-cycle unsigned restoring divider (inverse of the shift-add multiplier).
//   Computes Q = A / B and R = A % B, one quotient bit per clock, MSB first.
//   Uses the same start/fin handshake as the datapath's sequential multiplier,
//   so a controller can drive either unit.
// PARAMETERS
//   WIDTH  8  operand width; dividend A, divisor B, Q and R are all WIDTH bits
// PORTS
//   clk    in   1      single clock; all state updates on its rising edge
//   rst    in   1      reset, asynchronous, active-high
//   A      in   WIDTH  dividend, sampled while start=1
//   B      in   WIDTH  divisor, sampled while start=1
//   start  in   1      load/restart request, level-sensitive
//   Q      out  WIDTH  quotient, registered; valid from the fin cycle until next start
//   R      out  WIDTH  remainder, registered; same validity as Q
//   fin    out  1      one-cycle completion pulse
//   busy   out  1      high while iterating (RUN)
//   dz     out  1      divide-by-zero flag; port exists only with DIV_ZERO_FLAG_EN
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, working regs=0, Q=0, R=0, fin=0, busy=0, dz=0.
//   States IDLE, RUN, DONE.
//   - Any state, start=1 at edge: latch A into dividend shift reg and B into divisor reg;
//     clear partial remainder (WIDTH+1 bits) and cnt; Q, R, fin and dz <= 0;
//     go to RUN with busy=1. start has priority over every other transition.
//   - Holding start=1 reloads on every edge; no iteration happens while start=1.
//   - RUN, start=0: per edge, rem' = {rem[WIDTH-1:0], dvd[MSB]} and dvd <<= 1.
//     If rem' >= {1'b0,B}: rem <= rem' - B, quotient bit = 1; else rem <= rem', bit = 0.
//     Quotient bits shift in at the LSB. cnt increments once per iteration.
//   - Iteration WIDTH (cnt == WIDTH-1): the edge writes final Q and R, sets fin=1,
//     clears busy, and goes to DONE.
//   - DONE: at the next edge fin <= 0 and state goes to IDLE. Q and R hold.
//   - Latency: if start is last high at edge k, fin is high in the cycle after
//     edge k+WIDTH and lasts exactly one cycle.
//   - start=1 during DONE (fin high): restart; fin drops at that edge.
//   - start=1 mid-RUN: the current operation is aborted silently; no fin for it.
//   - rst mid-operation: asynchronous return to reset values; no fin.
//   - Widths: cnt is $clog2(WIDTH+1) bits. The subtract is WIDTH+1 bits wide, so
//     no overflow is possible. R < B always holds when B != 0.
// CONFIGURATION
//   DIV_ZERO_FLAG_EN defined:
//     - If B == 0 at load, RUN is skipped. The next edge with start=0 sets
//       Q=all-ones, R=A, fin=1, dz=1 and enters DONE (1-cycle latency).
//     - dz holds until the next start or rst.
//   Not defined:
//     - No dz port. B=0 runs the full WIDTH iterations and naturally yields
//       Q=all-ones, R=A.
// STRUCTURE
//   Package seq_div_pkg:
//     - state enum {IDLE, RUN, DONE}
//     - function cnt_w(width) = $clog2(width+1)
//   Sub-module seq_div_step (combinational): inputs rem, next dividend bit and B;
//   outputs new rem and the quotient bit. It is instantiated once.
// TESTING (WIDTH=8)
//   - A=200, B=7, start 1 cycle -> busy for 8 cycles; Q=28, R=4; fin high for
//     exactly 1 cycle, 8 edges after start falls.
//   - A=255, B=1 -> Q=255, R=0.  A=5, B=9 -> Q=0, R=5.  A=0, B=3 -> Q=0, R=0.
//   - A=77, B=0 -> Q=255, R=77, with dz=1 and 1-cycle latency if DIV_ZERO_FLAG_EN
//     is defined, else 8-cycle latency.
//   - Start 200/7, then start=1 at iteration 4 with A=100, B=10 -> only one fin,
//     carrying Q=10, R=0.
//   - Assert rst mid-RUN -> all outputs 0 immediately, no fin. Then hold start for
//     3 cycles with A=9, B=2 -> Q=4, R=1, fin 8 edges after start falls.
//   - Back-to-back: start asserted in the fin cycle -> the new result arrives
//     correctly and fin is never stuck high.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional feature macro: DIV_ZERO_FLAG_EN (see seq_div.sv).
package seq_div_pkg;

    // Controller states: waiting, iterating one quotient bit per clock, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; wide enough to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module seq_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // After a restore the remainder is always below the divisor, so its top
    // bit is never set going into a step; it is kept only for width symmetry.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem[WIDTH];
    assign shifted        = {rem[WIDTH-1:0], dvd_bit};
    assign diff           = shifted - {1'b0, b};

    // Keep the difference when the divisor fits, otherwise restore.
    always_comb begin
        q_bit    = (shifted >= {1'b0, b});
        rem_next = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider: Q = A / B, R = A % B, one quotient
// bit per clock, MSB first, with a start/fin handshake.
// Handshake: start is a level request sampled at every rising edge and
// overrides everything; each accepted operation that is not aborted produces
// exactly one single-cycle fin pulse, and Q/R are valid from that cycle until
// the next start.
// Optional feature: define DIV_ZERO_FLAG_EN to add the dz port and a
// one-cycle shortcut when the divisor is zero.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             fin,
    output logic             busy
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             dz
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    // Dividend shift register; vacated LSBs collect the quotient bits.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic             last;
    logic             zero_div;

    assign last = (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_FLAG_EN
    assign zero_div = (dsr == '0);
`else
    assign zero_div = 1'b0;
`endif

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[WIDTH-1]),
        .b        (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start wins over every other transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            RUN:     if (zero_div || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start) state_next = RUN;
    end

    // Datapath: load on start, iterate in RUN, drop fin in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dvd  <= '0;
            dsr  <= '0;
            rem  <= '0;
            Q    <= '0;
            R    <= '0;
            fin  <= 1'b0;
            busy <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz   <= 1'b0;
`endif
        end else if (start) begin
            cnt  <= '0;
            dvd  <= A;
            dsr  <= B;
            rem  <= '0;
            Q    <= '0;
            R    <= '0;
            fin  <= 1'b0;
            busy <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            dz   <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (zero_div) begin
                        Q    <= '1;
                        R    <= dvd;
                        fin  <= 1'b1;
                        busy <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                        dz   <= 1'b1;
`endif
                    end else begin
                        rem <= rem_next;
                        dvd <= {dvd[WIDTH-2:0], q_bit};
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            Q    <= {dvd[WIDTH-2:0], q_bit};
                            R    <= rem_next[WIDTH-1:0];
                            fin  <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                DONE:    fin <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (WIDTH=8) with a result scoreboard.
// Build with +define+DIV_ZERO_FLAG_EN to exercise the divide-by-zero flag.
module tb_seq_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         start;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         fin;
    logic         busy;
`ifdef DIV_ZERO_FLAG_EN
    logic         dz;
`endif

    int passed    = 0;
    int total     = 0;
    int fin_count = 0;
    int fc        = 0;
    logic [2*W-1:0] exp_q[$];

    seq_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a_in),
        .B     (b_in),
        .start (start),
        .Q     (q),
        .R     (r),
        .fin   (fin),
        .busy  (busy)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .dz    (dz)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    // Count every fin cycle, sampled mid-cycle.
    always @(negedge clk) if (fin === 1'b1) fin_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation; optionally push its reference result.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int hold, input bit expect_result);
        logic [W-1:0] qe;
        logic [W-1:0] re;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        repeat (hold) step();
        start = 1'b0;
        a_in  = W'($urandom_range(0, 255));
        b_in  = W'($urandom_range(0, 255));
        if (expect_result) begin
            qe = (b == 0) ? {W{1'b1}} : a / b;
            re = (b == 0) ? a : a % b;
            exp_q.push_back({qe, re});
        end
    endtask

    // Wait (bounded) for fin, check latency, busy span and the result.
    task automatic wait_fin(input string tag, input int exp_lat, input bit check_tail);
        int n = 0;
        int busy_n = 0;
        bit seen = 1'b0;
        logic [2*W-1:0] e;
        logic [W-1:0] q_hold;
        logic [W-1:0] r_hold;
        if (busy === 1'b1) busy_n++;
        while (n < 40 && !seen) begin
            step();
            n++;
            if (fin === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) busy_n++;
        end
        check({tag, "_fin_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_cycles"}, busy_n, exp_lat);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        check({tag, "_q"}, 32'(q), 32'(e[2*W-1:W]));
        check({tag, "_r"}, 32'(r), 32'(e[W-1:0]));
        if (check_tail) begin
            q_hold = e[2*W-1:W];
            r_hold = e[W-1:0];
            step();
            check({tag, "_fin_drop"}, 32'(fin), 32'd0);
            check({tag, "_q_hold"}, 32'(q), 32'(q_hold));
            check({tag, "_r_hold"}, 32'(r), 32'(r_hold));
        end
    endtask

    initial begin
        logic [W-1:0] ta [6];
        logic [W-1:0] tb_ [6];
        ta  = '{8'd255, 8'd5, 8'd0, 8'd128, 8'd0, 8'd0};
        tb_ = '{8'd1,   8'd9, 8'd3, 8'd128, 8'd0, 8'd0};
        ta[4]  = W'($urandom_range(0, 255));
        tb_[4] = W'($urandom_range(1, 255));
        ta[5]  = W'($urandom_range(0, 255));
        tb_[5] = W'($urandom_range(1, 15));

        // Reset.
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        check("rst_q", 32'(q), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_fin", 32'(fin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst_dz", 32'(dz), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Basic operation.
        fc = fin_count;
        start_op(8'd200, 8'd7, 1, 1'b1);
        check("d200_busy_start", 32'(busy), 32'd1);
        wait_fin("d200_7", 8, 1'b1);
        check("d200_one_fin", fin_count - fc, 32'd1);

        // Table of operand patterns.
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb_[i], 1, 1'b1);
            wait_fin($sformatf("tab%0d", i), 8, 1'b1);
        end

        // Divide by zero.
        start_op(8'd77, 8'd0, 1, 1'b1);
`ifdef DIV_ZERO_FLAG_EN
        wait_fin("dz77", 1, 1'b0);
        check("dz_set", 32'(dz), 32'd1);
        step();
        check("dz_fin_drop", 32'(fin), 32'd0);
        check("dz_hold", 32'(dz), 32'd1);
        start_op(8'd77, 8'd5, 1, 1'b1);
        check("dz_clear_on_start", 32'(dz), 32'd0);
        wait_fin("dz_next", 8, 1'b1);
`else
        wait_fin("dz77", 8, 1'b1);
`endif

        // Abort mid-RUN: only the restarted operation finishes.
        fc = fin_count;
        start_op(8'd200, 8'd7, 1, 1'b0);
        repeat (4) step();
        start_op(8'd100, 8'd10, 1, 1'b1);
        wait_fin("abort", 8, 1'b1);
        check("abort_one_fin", fin_count - fc, 32'd1);

        // Asynchronous reset mid-RUN, then a held start.
        fc = fin_count;
        start_op(8'd200, 8'd7, 1, 1'b0);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'd0);
        check("arst_r", 32'(r), 32'd0);
        check("arst_fin", 32'(fin), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        start_op(8'd9, 8'd2, 3, 1'b1);
        wait_fin("held9_2", 8, 1'b1);
        check("arst_one_fin", fin_count - fc, 32'd1);

        // Back-to-back: restart in the fin cycle.
        start_op(8'd50, 8'd6, 1, 1'b1);
        wait_fin("b2b_first", 8, 1'b0);
        start_op(8'd123, 8'd11, 1, 1'b1);
        check("b2b_fin_drop", 32'(fin), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_fin("b2b_second", 8, 1'b1);
        repeat (3) step();
        check("b2b_fin_idle", 32'(fin), 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
